// File: rtl/return_stack_ctrl.sv
// return_stack_ctrl
//   Subroutine return-address controller in front of a 16-bit hardware LIFO.
//   It turns single-cycle CALL/RET strobes into registered push/pop commands.
//   On CALL it writes pc+1 to the LIFO. On RET it captures the popped word
//   for the PC load path. It keeps its own occupancy count, so overflow and
//   underflow are caught before the LIFO is driven.
//
//   Optional feature macro: RSTACK_SYNC_CHECK_EN
//     When defined, lifo_empty and lifo_full are compared against the local
//     occupancy count while the FSM is in IDLE. Any mismatch sets err_sync.
//     When undefined, err_sync is tied to 0.
//
//   Ports
//     clock, resetn        rising-edge clock; async active-low reset
//     call, ret, pc        command strobes and the CALL instruction address
//     clear_err            synchronous clear of the sticky error bits
//     busy                 high while a command is in flight
//     ret_valid, ret_addr  one-cycle pulse with the popped return address
//     depth_cnt            controller occupancy count
//     err_ovf/udf/col/sync sticky error flags
//     lifo_push/pop/data   registered commands to the LIFO
//     lifo_q/full/empty    LIFO read data and status
//
//   state | meaning
//   IDLE  | waiting for CALL/RET
//   PUSH  | lifo_push asserted for this cycle
//   POP   | lifo_pop asserted for this cycle
//   CAPT  | lifo_q valid; capture into ret_addr and pulse ret_valid

module return_stack_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             call,
  input  logic             ret,
  input  logic [15:0]      pc,
  input  logic             clear_err,
  output logic             busy,
  output logic             ret_valid,
  output logic [15:0]      ret_addr,
  output logic [CNT_W-1:0] depth_cnt,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_col,
  output logic             err_sync,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [15:0]      lifo_data,
  input  logic [15:0]      lifo_q,
  input  logic             lifo_full,
  input  logic             lifo_empty
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2,
    ST_CAPT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           r_state;
  logic             r_ret_valid;
  logic [15:0]      r_ret_addr;
  logic [CNT_W-1:0] r_depth_cnt;
  logic             r_err_ovf;
  logic             r_err_udf;
  logic             r_err_col;
  logic             r_lifo_push;
  logic             r_lifo_pop;
  logic [15:0]      r_lifo_data;

`ifdef RSTACK_SYNC_CHECK_EN
  logic r_err_sync;
  logic w_sync_mis;
  assign w_sync_mis = (lifo_empty != (r_depth_cnt == '0)) ||
                      (lifo_full  != (r_depth_cnt == DEPTH_C));
`else
  logic w_unused_status;
  assign w_unused_status = lifo_full ^ lifo_empty;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_ret_valid <= 1'b0;
      r_ret_addr  <= 16'h0000;
      r_depth_cnt <= '0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_err_col   <= 1'b0;
      r_lifo_push <= 1'b0;
      r_lifo_pop  <= 1'b0;
      r_lifo_data <= 16'h0000;
`ifdef RSTACK_SYNC_CHECK_EN
      r_err_sync  <= 1'b0;
`endif
    end else begin
      r_ret_valid <= 1'b0;

      // Clear comes first so that any error raised below on the same edge wins.
      if (clear_err) begin
        r_err_ovf <= 1'b0;
        r_err_udf <= 1'b0;
        r_err_col <= 1'b0;
`ifdef RSTACK_SYNC_CHECK_EN
        r_err_sync <= 1'b0;
`endif
      end

`ifdef RSTACK_SYNC_CHECK_EN
      if (r_state == ST_IDLE && w_sync_mis) r_err_sync <= 1'b1;
`endif

      case (r_state)
        ST_IDLE: begin
          if (call) begin
            // A simultaneous RET is dropped; the CALL takes the slot.
            if (ret) r_err_col <= 1'b1;
            if (r_depth_cnt != DEPTH_C) begin
              r_lifo_data <= pc + 16'd1;
              r_lifo_push <= 1'b1;
              r_depth_cnt <= r_depth_cnt + CNT_W'(1);
              r_state     <= ST_PUSH;
            end else begin
              r_err_ovf <= 1'b1;
            end
          end else if (ret) begin
            if (r_depth_cnt != '0) begin
              r_lifo_pop  <= 1'b1;
              r_depth_cnt <= r_depth_cnt - CNT_W'(1);
              r_state     <= ST_POP;
            end else begin
              r_err_udf <= 1'b1;
            end
          end
        end
        ST_PUSH: begin
          r_lifo_push <= 1'b0;
          if (call || ret) r_err_col <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_POP: begin
          r_lifo_pop <= 1'b0;
          if (call || ret) r_err_col <= 1'b1;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_ret_addr  <= lifo_q;
          r_ret_valid <= 1'b1;
          if (call || ret) r_err_col <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign ret_valid = r_ret_valid;
  assign ret_addr  = r_ret_addr;
  assign depth_cnt = r_depth_cnt;
  assign err_ovf   = r_err_ovf;
  assign err_udf   = r_err_udf;
  assign err_col   = r_err_col;
  assign lifo_push = r_lifo_push;
  assign lifo_pop  = r_lifo_pop;
  assign lifo_data = r_lifo_data;
`ifdef RSTACK_SYNC_CHECK_EN
  assign err_sync  = r_err_sync;
`else
  assign err_sync  = 1'b0;
`endif

endmodule
